// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and widths for the ALU command sequencer.
package alu_pkg;

    localparam int DW = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_seq.sv
// Command sequencer feeding the 8-bit combinational ALU, with accumulator.
// Optional divide-by-zero trap: define ALU_DIVZERO_TRAP_EN.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter logic [DW-1:0] ACC_INIT = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic          cmd_use_acc,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_carry,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_carry,
    output logic          res_zero,
    output logic          res_err,
    output logic [DW-1:0] acc_out
);

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] data_q, data_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic          trap_q, trap_d;
    logic          trap_cmd;

`ifdef ALU_DIVZERO_TRAP_EN
    assign trap_cmd = (cmd_op == OP_DIV) && (cmd_b == '0);
`else
    assign trap_cmd = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;
        data_d    = data_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;
        trap_d    = trap_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_use_acc ? acc_q : cmd_a;
                    b_d     = cmd_b;
                    trap_d  = trap_cmd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (trap_q) begin
                    // Trapped divide: ALU output is garbage, accumulator kept
                    data_d  = 8'hFF;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    data_d  = alu_out;
                    carry_d = (op_q == OP_ADD) && alu_carry;
                    zero_d  = (alu_out == '0);
                    err_d   = 1'b0;
                    acc_d   = alu_out;
                end
                state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= ACC_INIT;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            trap_q  <= trap_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = op_q;
    assign res_data  = data_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;
    assign res_err   = err_q;
    assign acc_out   = acc_q;

endmodule
